// File: rtl/mips_alu_pkg.sv
// Shared ALU opcode constants (common with the ALU control decoder) and the
// execution-unit FSM state encoding.
package mips_alu_pkg;

  localparam logic [3:0] ALU_LUI     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_SLL     = 4'b0010;
  localparam logic [3:0] ALU_ADD     = 4'b0011;
  localparam logic [3:0] ALU_SRL     = 4'b0100;
  localparam logic [3:0] ALU_SUB     = 4'b0101;
  localparam logic [3:0] ALU_AND     = 4'b0110;
  localparam logic [3:0] ALU_NOR     = 4'b0111;
  localparam logic [3:0] ALU_INVALID = 4'b1001;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations and unsupported-opcode flag. Shift opcodes pass
// operand B through unchanged; that is the correct result for a zero shift.
module alu_comb_core
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_operation_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             error_o
);

  always_comb begin
    result_o = '0;
    error_o  = 1'b0;
    case (alu_operation_i)
      ALU_LUI: result_o = {b_i[15:0], {(WIDTH-16){1'b0}}};
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLL: result_o = b_i;
      ALU_ADD: result_o = a_i + b_i;
      ALU_SRL: result_o = b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_NOR: result_o = ~(a_i | b_i);
      default: error_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_multicycle_exec.sv
// ALU execution unit: single-cycle logic/arith, iterative 1-bit/cycle shifter.
// Define ALU_BARREL_SHIFT_EN to replace the iterative shifter with a barrel shifter.
//
// state | meaning
// IDLE  | ready; accepts start_i, single-cycle ops complete from here
// SHIFT | iterative shift in progress, busy_o high, start_i ignored
module alu_multicycle_exec
  import mips_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [3:0]         alu_operation_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   result_o,
  output logic               zero_o,
  output logic               error_o
);

  logic [WIDTH-1:0] core_result;
  logic             core_error;

  alu_comb_core #(.WIDTH(WIDTH)) u_comb_core (
    .alu_operation_i (alu_operation_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .result_o        (core_result),
    .error_o         (core_error)
  );

`ifdef ALU_BARREL_SHIFT_EN

  logic [WIDTH-1:0] imm_result;

  always_comb begin
    imm_result = core_result;
    if (alu_operation_i == ALU_SLL)
      imm_result = b_i << shamt_i;
    else if (alu_operation_i == ALU_SRL)
      imm_result = b_i >> shamt_i;
  end

  assign busy_o = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_o   <= 1'b0;
      result_o <= '0;
      zero_o   <= 1'b1;
      error_o  <= 1'b0;
    end else begin
      done_o <= start_i;
      if (start_i) begin
        result_o <= imm_result;
        zero_o   <= (imm_result == '0);
        error_o  <= core_error;
      end
    end
  end

`else

  alu_state_t         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [WIDTH-1:0]   shreg_next;
  logic               dir_srl_q;
  logic               accept_imm;
  logic               load_shift;
  logic               finish_shift;

  assign shreg_next = dir_srl_q ? (shreg_q >> 1) : (shreg_q << 1);
  assign busy_o     = (state_q == ST_SHIFT);

  always_comb begin
    state_d      = state_q;
    accept_imm   = 1'b0;
    load_shift   = 1'b0;
    finish_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (is_shift_op(alu_operation_i) && (shamt_i != '0)) begin
            load_shift = 1'b1;
            state_d    = ST_SHIFT;
          end else begin
            accept_imm = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (cnt_q == SHAMT_W'(1)) begin
          finish_shift = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Operands are captured on accept, so inputs are free to change during SHIFT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      shreg_q   <= '0;
      dir_srl_q <= 1'b0;
      done_o    <= 1'b0;
      result_o  <= '0;
      zero_o    <= 1'b1;
      error_o   <= 1'b0;
    end else begin
      done_o <= accept_imm | finish_shift;
      if (load_shift) begin
        shreg_q   <= b_i;
        cnt_q     <= shamt_i;
        dir_srl_q <= (alu_operation_i == ALU_SRL);
      end else if (state_q == ST_SHIFT) begin
        shreg_q <= shreg_next;
        cnt_q   <= cnt_q - SHAMT_W'(1);
      end
      if (accept_imm) begin
        result_o <= core_result;
        zero_o   <= (core_result == '0);
        error_o  <= core_error;
      end else if (finish_shift) begin
        result_o <= shreg_next;
        zero_o   <= (shreg_next == '0);
        error_o  <= 1'b0;
      end
    end
  end

`endif

endmodule

// File: tb/tb_alu_multicycle_exec.sv
// Self-checking bench for alu_multicycle_exec: directed cases from the test
// plan followed by randomized operations against a behavioural model.
module tb_alu_multicycle_exec;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [3:0]  alu_operation_i;
  logic [31:0] a_i, b_i;
  logic [4:0]  shamt_i;
  logic        busy_o, done_o, zero_o, error_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_multicycle_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .alu_operation_i (alu_operation_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .shamt_i         (shamt_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .result_o        (result_o),
    .zero_o          (zero_o),
    .error_o         (error_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model: what the instruction means, independent of timing.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] res,
                                output logic err, output int lat);
    err = 1'b0;
    lat = 1;
    case (op)
      4'd0: res = b * 32'h0001_0000;
      4'd1: res = a | b;
      4'd2: begin res = b << sh; if (!BARREL) lat = int'(sh) + 1; end
      4'd3: res = a + b;
      4'd4: begin res = b >> sh; if (!BARREL) lat = int'(sh) + 1; end
      4'd5: res = a - b;
      4'd6: res = a & b;
      4'd7: res = ~(a | b);
      default: begin res = 32'h0; err = 1'b1; end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_lat, cyc, busy_cnt;
    bit          seen;
    model(op, a, b, sh, exp_res, exp_err, exp_lat);
    start_i = 1'b1; alu_operation_i = op; a_i = a; b_i = b; shamt_i = sh;
    cyc = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      start_i = 1'b0;
      alu_operation_i = 4'($urandom); a_i = $urandom; b_i = $urandom; shamt_i = 5'($urandom);
      cyc++;
      if (busy_o) busy_cnt++;
      if (done_o) seen = 1'b1;
    end
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " busy_cycles"}, busy_cnt, exp_lat - 1);
    check({tag, " result"}, result_o, exp_res);
    check({tag, " zero"}, {31'b0, zero_o}, {31'b0, exp_res == 32'h0});
    check({tag, " error"}, {31'b0, error_o}, {31'b0, exp_err});
    @(negedge clk);
    check({tag, " done_pulse"}, {31'b0, done_o}, 32'h0);
    check({tag, " hold"}, result_o, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    reset = 1'b0; start_i = 1'b0; alu_operation_i = 4'h0; a_i = 0; b_i = 0; shamt_i = 0;
    repeat (3) @(negedge clk);
    check("rst busy", {31'b0, busy_o}, 32'h0);
    check("rst done", {31'b0, done_o}, 32'h0);
    check("rst result", result_o, 32'h0);
    check("rst zero", {31'b0, zero_o}, 32'h1);
    check("rst error", {31'b0, error_o}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // ADD then SUB back-to-back
    start_i = 1'b1; alu_operation_i = 4'b0011; a_i = 5; b_i = 7;
    @(negedge clk);
    check("add done", {31'b0, done_o}, 32'h1);
    check("add result", result_o, 32'd12);
    check("add zero", {31'b0, zero_o}, 32'h0);
    check("add error", {31'b0, error_o}, 32'h0);
    alu_operation_i = 4'b0101; a_i = 5; b_i = 5;
    @(negedge clk);
    start_i = 1'b0;
    check("sub done", {31'b0, done_o}, 32'h1);
    check("sub result", result_o, 32'd0);
    check("sub zero", {31'b0, zero_o}, 32'h1);
    @(negedge clk);

    run_op("lui", 4'b0000, 32'h0, 32'h0000_1234, 5'd0);
    run_op("nor", 4'b0111, 32'h0, 32'h0, 5'd0);
    run_op("sub_wrap", 4'b0101, 32'h0, 32'h1, 5'd0);
    run_op("sll4", 4'b0010, 32'h0, 32'h1, 5'd4);
    run_op("srl31", 4'b0100, 32'h0, 32'h8000_0000, 5'd31);
    run_op("sll31", 4'b0010, 32'h0, 32'hFFFF_FFFF, 5'd31);
    run_op("sll0", 4'b0010, 32'h0, 32'hA5A5_0001, 5'd0);
    run_op("op1001", 4'b1001, 32'h1, 32'h2, 5'd0);
    run_op("op1111", 4'b1111, 32'h1, 32'h2, 5'd0);
    run_op("add_ovf", 4'b0011, 32'hFFFF_FFFF, 32'h2, 5'd0);

`ifndef ALU_BARREL_SHIFT_EN
    // start_i during a shift is ignored
    start_i = 1'b1; alu_operation_i = 4'b0010; a_i = 0; b_i = 3; shamt_i = 5'd8;
    n_done = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start_i = (i == 3);
      alu_operation_i = 4'b0011; a_i = 1; b_i = 1; shamt_i = 0;
      if (done_o) begin
        n_done++;
        check("ignore done_cycle", i, 9);
        check("ignore result", result_o, 32'd768);
      end
    end
    check("ignore done_count", n_done, 1);

    // start on the cycle busy falls is accepted
    start_i = 1'b1; alu_operation_i = 4'b0100; b_i = 32'h40; shamt_i = 5'd2;
    n_done = 0;
    for (int i = 1; i <= 6 && n_done == 0; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o) n_done++;
    end
    check("busyfall srl", result_o, 32'h10);
    check("busyfall busy", {31'b0, busy_o}, 32'h0);
    start_i = 1'b1; alu_operation_i = 4'b0011; a_i = 2; b_i = 3;
    @(negedge clk);
    start_i = 1'b0;
    check("busyfall add_done", {31'b0, done_o}, 32'h1);
    check("busyfall add_result", result_o, 32'd5);
    @(negedge clk);

    // reset mid-shift when the remaining count is 3
    start_i = 1'b1; alu_operation_i = 4'b0010; b_i = 1; shamt_i = 5'd10;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    check("midrst busy_before", {31'b0, busy_o}, 32'h1);
    #1 reset = 1'b0;
    #1;
    check("midrst busy", {31'b0, busy_o}, 32'h0);
    check("midrst result", result_o, 32'h0);
    check("midrst zero", {31'b0, zero_o}, 32'h1);
    check("midrst done", {31'b0, done_o}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_o) n_done++;
    end
    check("midrst no_done", n_done, 0);
    run_op("post_rst_add", 4'b0011, 32'd100, 32'd23, 5'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = (i % 4 == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      run_op("rand", op, $urandom, (i % 5 == 0) ? 32'h0 : $urandom, 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
